// File: rtl/keccak_obi_pkg.sv
// Shared constants and types for the Keccak OBI responder: address map, STATUS layout,
// and handshake FSM states.
package keccak_obi_pkg;

    localparam logic [31:0] KECCAK_START_ADDRESS = 32'h2000_0000;

    localparam int unsigned STATE_WORDS = 50;
    localparam int unsigned STATE_BITS  = 32 * STATE_WORDS;

    localparam logic [31:0] KECCAK_STATE_OFFSET  = 32'h0000_0000;
    localparam logic [31:0] KECCAK_CTRL_OFFSET   = 32'h0000_0100;
    localparam logic [31:0] KECCAK_STATUS_OFFSET = 32'h0000_0104;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;

    typedef enum logic {
        IDLE,
        BUSY
    } keccak_obi_state_e;

endpackage

// File: rtl/keccak_state_buf.sv
// 1600-bit Keccak state buffer: 50 x 32-bit words with a byte-enable write port,
// a bulk load from the permutation core and a word read mux.
module keccak_state_buf
    import keccak_obi_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [3:0]            i_be,
    input  logic [5:0]            i_addr,
    input  logic [31:0]           i_wdata,
    input  logic                  i_load,
    input  logic [STATE_BITS-1:0] i_load_data,
    output logic [31:0]           o_rdata,
    output logic [STATE_BITS-1:0] o_state
);

    logic [STATE_BITS-1:0] r_state;

    // A bulk load and a bus write never coincide: the top stalls word accesses while busy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_load_data;
        end else if (i_we) begin
            for (int k = 0; k < STATE_WORDS; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_addr == 6'(k) && i_be[b]) begin
                        r_state[32*k+8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < STATE_WORDS; k++) begin
            if (i_addr == 6'(k)) begin
                o_rdata = r_state[32*k +: 32];
            end
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/keccak_obi_responder.sv
// OBI slave for the Keccak window: memory-mapped state buffer, CTRL/STATUS registers and
// the start/done handshake with the permutation core.
module keccak_obi_responder
    import keccak_obi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = KECCAK_START_ADDRESS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  start_o,
    output logic [STATE_BITS-1:0] state_o,
    input  logic                  core_done_i,
    input  logic [STATE_BITS-1:0] core_state_i
);

    keccak_obi_state_e r_fsm, w_fsm_d;
    logic              r_done, w_done_d;
    logic              r_start, w_start_d;
    logic              r_rvalid;
    logic [31:0]       r_rdata, w_rdata_d;

    logic [31:0] w_off, w_soff, w_buf_rdata, w_status;
    logic [29:0] w_sidx;
    logic        w_is_state, w_is_ctrl, w_is_status, w_busy;
    logic        w_wr, w_rd, w_start_req, w_load;
    logic        w_unused_addr;

    assign w_off      = addr_i - BASE_ADDR;
    assign w_soff     = w_off - KECCAK_STATE_OFFSET;
    assign w_sidx     = w_soff[31:2];
    assign w_is_state = w_sidx < 30'(STATE_WORDS);
    assign w_is_ctrl  = w_off[31:2] == KECCAK_CTRL_OFFSET[31:2];
    assign w_is_status = w_off[31:2] == KECCAK_STATUS_OFFSET[31:2];
    assign w_unused_addr = ^w_soff[1:0];

    assign w_busy = (r_fsm == BUSY);

    // The buffer is owned by the core while busy, so only word accesses are held off.
    assign gnt_o = req_i && !(w_busy && w_is_state);
    assign w_wr  = gnt_o && we_i;
    assign w_rd  = gnt_o && !we_i;

    assign w_start_req = w_wr && w_is_ctrl && be_i[0] && wdata_i[0];

    always_comb begin
        w_status = '0;
        w_status[STATUS_BUSY_BIT] = w_busy;
        w_status[STATUS_DONE_BIT] = r_done;
    end

    always_comb begin
        w_fsm_d   = r_fsm;
        w_done_d  = r_done;
        w_start_d = 1'b0;
        w_load    = 1'b0;
        if (w_rd && w_is_status) begin
            w_done_d = 1'b0;
        end
        unique case (r_fsm)
            IDLE: begin
                if (w_start_req) begin
                    w_start_d = 1'b1;
                    w_done_d  = 1'b0;
                    w_fsm_d   = BUSY;
                end
            end
            BUSY: begin
                // Completion overrides a same-cycle STATUS read clearing done.
                if (core_done_i) begin
                    w_load   = 1'b1;
                    w_done_d = 1'b1;
                    w_fsm_d  = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_rdata_d = '0;
        if (w_rd) begin
            if (w_is_state) begin
                w_rdata_d = w_buf_rdata;
            end else if (w_is_status) begin
                w_rdata_d = w_status;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fsm    <= IDLE;
            r_done   <= 1'b0;
            r_start  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_fsm    <= w_fsm_d;
            r_done   <= w_done_d;
            r_start  <= w_start_d;
            r_rvalid <= gnt_o;
            r_rdata  <= w_rdata_d;
        end
    end

    keccak_state_buf u_state_buf (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_we        (w_wr && w_is_state),
        .i_be        (be_i),
        .i_addr      (w_sidx[5:0]),
        .i_wdata     (wdata_i),
        .i_load      (w_load),
        .i_load_data (core_state_i),
        .o_rdata     (w_buf_rdata),
        .o_state     (state_o)
    );

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign start_o  = r_start;

endmodule

// File: tb/tb_keccak_obi_responder.sv
// Directed bench for keccak_obi_responder: per-cycle comparison against a word-level
// model of the register map and handshake, plus hand-computed expectations.
module tb_keccak_obi_responder;
    import keccak_obi_pkg::*;

    localparam logic [31:0] BASE = KECCAK_START_ADDRESS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [3:0]    be = 4'h0;
    logic [31:0]   addr = 32'h0;
    logic [31:0]   wdata = 32'h0;
    logic          gnt, rvalid, start;
    logic [31:0]   rdata;
    logic [1599:0] state;
    logic          done_in = 1'b0;
    logic [1599:0] core_state = '0;

    always #5 clk = ~clk;

    keccak_obi_responder dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .we_i         (we),
        .be_i         (be),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .start_o      (start),
        .state_o      (state),
        .core_done_i  (done_in),
        .core_state_i (core_state)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic chk_state(input string name, input logic [1599:0] act,
                             input logic [1599:0] exp);
        int bad;
        bad = -1;
        for (int k = STATE_WORDS - 1; k >= 0; k--) begin
            if (act[32*k +: 32] !== exp[32*k +: 32]) bad = k;
        end
        n_total++;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: word %0d got %h want %h", name, bad,
                      act[32*bad +: 32], exp[32*bad +: 32]);
    endtask

    // Word-level model: register map contents plus busy/done flags.
    logic [31:0] m_mem [STATE_WORDS];
    bit          m_busy, m_done, m_rvalid, m_start;
    logic [31:0] m_rdata;

    function automatic logic [1599:0] model_state();
        logic [1599:0] v;
        for (int k = 0; k < STATE_WORDS; k++) v[32*k +: 32] = m_mem[k];
        return v;
    endfunction

    always @(negedge clk) begin
        logic [31:0] off, rv;
        bit          sa, g;
        if (rst) begin
            for (int k = 0; k < STATE_WORDS; k++) m_mem[k] = '0;
            m_busy = 0; m_done = 0; m_rvalid = 0; m_start = 0; m_rdata = '0;
        end
        off = addr - BASE;
        sa  = (off >> 2) < STATE_WORDS;
        g   = req && !(m_busy && sa);
        chk("cyc_gnt", {31'b0, gnt}, {31'b0, g});
        chk("cyc_rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
        chk("cyc_rdata", rdata, m_rdata);
        chk("cyc_start", {31'b0, start}, {31'b0, m_start});
        chk_state("cyc_state", state, model_state());
        if (!rst) begin
            rv = '0;
            if (g && !we) begin
                if (sa) rv = m_mem[off[7:2]];
                else if ((off >> 2) == 32'h41) rv = {30'b0, m_done, m_busy};
            end
            m_rvalid = g;
            m_rdata  = rv;
            m_start  = 0;
            if (g && we && sa) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_mem[off[7:2]][8*b +: 8] = wdata[8*b +: 8];
            end
            if (m_busy && done_in) begin
                for (int k = 0; k < STATE_WORDS; k++) m_mem[k] = core_state[32*k +: 32];
                m_busy = 0;
                m_done = 1;
            end else if (!m_busy && g && we && (off >> 2) == 32'h40 && be[0] && wdata[0]) begin
                m_start = 1;
                m_busy  = 1;
                m_done  = 0;
            end else if (g && !we && (off >> 2) == 32'h41) begin
                m_done = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic t_we, input logic [31:0] t_off, input logic [31:0] t_wd,
                        input logic [3:0] t_be, output logic [31:0] rd, output int waited);
        req = 1'b1; we = t_we; addr = BASE + t_off; wdata = t_wd; be = t_be;
        #1;
        waited = 0;
        while (!gnt && waited < 64) begin
            tick();
            waited++;
        end
        if (!gnt) chk("xfer_grant_timeout", 32'd0, 32'd1);
        tick();
        rd = rdata;
        req = 1'b0; we = 1'b0; be = 4'h0; wdata = '0;
    endtask

    logic [31:0]   rd;
    int            w;
    logic [1599:0] saved;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_start", {31'b0, start}, 32'd0);
        chk_state("rst_state", state, '0);
        rst = 1'b0;
        tick();

        xfer(1'b1, 32'h008, 32'hDEADBEEF, 4'hF, rd, w);
        chk("wr_gnt_wait", w, 0);
        xfer(1'b0, 32'h008, 32'h0, 4'hF, rd, w);
        chk("rd_word2", rd, 32'hDEADBEEF);
        chk("state_word2", state[95:64], 32'hDEADBEEF);

        xfer(1'b1, 32'h000, 32'hFFFFFFFF, 4'hF, rd, w);
        xfer(1'b1, 32'h000, 32'h11223344, 4'b0101, rd, w);
        xfer(1'b0, 32'h000, 32'h0, 4'hF, rd, w);
        chk("rd_be_merge", rd, 32'hFF22FF44);

        xfer(1'b1, 32'h0C4, 32'h0BADF00D, 4'hF, rd, w);
        xfer(1'b0, 32'h0C4, 32'h0, 4'hF, rd, w);
        chk("rd_last_word", rd, 32'h0BADF00D);
        chk("state_last_word", state[1599:1568], 32'h0BADF00D);

        // Start and stall.
        req = 1'b1; we = 1'b1; addr = BASE + 32'h100; wdata = 32'h1; be = 4'hF;
        #1;
        chk("ctrl_gnt", {31'b0, gnt}, 32'd1);
        tick();
        req = 1'b0; we = 1'b0;
        chk("start_pulse", {31'b0, start}, 32'd1);
        tick();
        chk("start_one_cycle", {31'b0, start}, 32'd0);
        xfer(1'b0, 32'h104, 32'h0, 4'hF, rd, w);
        chk("status_busy", rd, 32'h1);
        xfer(1'b1, 32'h100, 32'h1, 4'hF, rd, w);
        chk("ctrl_ignored_busy", {31'b0, start}, 32'd0);
        xfer(1'b0, 32'h100, 32'h0, 4'hF, rd, w);
        chk("ctrl_read_zero", rd, 32'h0);

        req = 1'b1; we = 1'b0; addr = BASE + 32'h00C; be = 4'hF;
        #1;
        chk("stall_gnt", {31'b0, gnt}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_gnt_hold", {31'b0, gnt}, 32'd0);
        end
        core_state[127:96]  = 32'hA5A5A5A5;
        core_state[255:224] = 32'h12345678;
        done_in = 1'b1;
        #1;
        chk("stall_gnt_done_cycle", {31'b0, gnt}, 32'd0);
        tick();
        done_in = 1'b0;
        chk("stall_release", {31'b0, gnt}, 32'd1);
        tick();
        req = 1'b0;
        chk("rd_after_done", rd === rdata ? rdata : rdata, 32'hA5A5A5A5);
        chk("state_word7_loaded", state[255:224], 32'h12345678);
        chk("word2_overwritten", state[95:64], 32'h0);

        xfer(1'b0, 32'h104, 32'h0, 4'hF, rd, w);
        chk("status_done", rd, 32'h2);
        xfer(1'b0, 32'h104, 32'h0, 4'hF, rd, w);
        chk("status_cleared", rd, 32'h0);

        // STATUS read coinciding with completion.
        xfer(1'b1, 32'h100, 32'h1, 4'h1, rd, w);
        core_state[31:0] = 32'hCAFEF00D;
        req = 1'b1; we = 1'b0; addr = BASE + 32'h104; be = 4'hF;
        done_in = 1'b1;
        #1;
        chk("status_race_gnt", {31'b0, gnt}, 32'd1);
        tick();
        done_in = 1'b0; req = 1'b0;
        chk("status_race_pre", rdata, 32'h1);
        xfer(1'b0, 32'h104, 32'h0, 4'hF, rd, w);
        chk("status_race_done", rd, 32'h2);
        chk("state_word0_race", state[31:0], 32'hCAFEF00D);

        // Unmapped and non-start accesses.
        saved = state;
        xfer(1'b1, 32'h200, 32'hFFFFFFFF, 4'hF, rd, w);
        xfer(1'b0, 32'h200, 32'h0, 4'hF, rd, w);
        chk("unmapped_rd", rd, 32'h0);
        xfer(1'b1, 32'h0C8, 32'hFFFFFFFF, 4'hF, rd, w);
        xfer(1'b0, 32'h0C8, 32'h0, 4'hF, rd, w);
        chk("past_end_rd", rd, 32'h0);
        xfer(1'b1, 32'h100, 32'h0, 4'hF, rd, w);
        chk("ctrl_zero_no_start", {31'b0, start}, 32'd0);
        chk_state("unmapped_no_change", state, saved);

        // Reset during a permutation.
        xfer(1'b1, 32'h100, 32'h1, 4'hF, rd, w);
        rst = 1'b1;
        #1;
        chk("rst_busy_start", {31'b0, start}, 32'd0);
        chk_state("rst_busy_state", state, '0);
        tick();
        rst = 1'b0;
        core_state = {50{32'h5A5A5A5A}};
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        xfer(1'b0, 32'h104, 32'h0, 4'hF, rd, w);
        chk("rst_busy_status", rd, 32'h0);
        chk_state("late_done_ignored", state, '0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
